// File: rtl/pri_decoder_strobe.sv
`default_nettype none
// ============================================================================
// Module   : pri_decoder_strobe
// Purpose  : Binary-to-one-hot decoder with timed strobe generation. A code is
//            accepted over a valid/ready handshake. The matching one-hot line
//            is then driven for HOLD_CYCLES clocks, followed by GAP_CYCLES
//            all-zero clocks. A one-entry pending buffer lets the next code be
//            accepted while a strobe is still running.
// Ports    : clk          - rising-edge clock
//            reset_n      - synchronous reset, active low
//            enable       - block enable; low aborts activity and blocks accepts
//            binary_in    - code to decode (WIDTH_IN bits)
//            in_valid     - binary_in is valid
//            in_ready     - a code can be accepted this cycle
//            decoder_out  - one-hot strobe (2**WIDTH_IN bits), zero when idle
//            out_valid    - high while decoder_out is nonzero
//            busy         - strobe or gap active, or pending entry held
// Revision : 1.0 - initial release
// ============================================================================
module pri_decoder_strobe #(
  parameter int WIDTH_IN    = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [WIDTH_IN-1:0]      binary_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [2**WIDTH_IN-1:0]   decoder_out,
  output logic                     out_valid,
  output logic                     busy
);

  localparam int OUT_W   = 2**WIDTH_IN;
  localparam int CNT_MAX = ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  // With no gap the reload value is never used; keep it at zero.
  localparam logic [CNT_W-1:0] GAP_RELOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1)
                                                              : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [OUT_W-1:0]    dec_q,        dec_d;
  logic                ov_q,         ov_d;
  logic                pend_valid_q, pend_valid_d;
  logic [WIDTH_IN-1:0] pend_code_q,  pend_code_d;

  logic accept;

  assign in_ready    = reset_n & enable & ~pend_valid_q;
  assign accept      = in_valid & in_ready;
  assign decoder_out = dec_q;
  assign out_valid   = ov_q;
  assign busy        = (state_q != ST_IDLE) | pend_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dec_d        = dec_q;
    ov_d         = ov_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;

    if (!enable) begin
      // Abort: no partial strobe survives a disable.
      state_d      = ST_IDLE;
      cnt_d        = '0;
      dec_d        = '0;
      ov_d         = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_RELOAD;
            dec_d   = OUT_W'(1) << binary_in;
            ov_d    = 1'b1;
          end
        end

        ST_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (accept) begin
              pend_valid_d = 1'b1;
              pend_code_d  = binary_in;
            end
          end else if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_RELOAD;
            dec_d   = '0;
            ov_d    = 1'b0;
            if (accept) begin
              pend_valid_d = 1'b1;
              pend_code_d  = binary_in;
            end
          end else if (pend_valid_q) begin
            // in_ready is low here, so no accept can coincide.
            cnt_d        = HOLD_RELOAD;
            dec_d        = OUT_W'(1) << pend_code_q;
            ov_d         = 1'b1;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            // Back-to-back bypass straight from the input.
            cnt_d = HOLD_RELOAD;
            dec_d = OUT_W'(1) << binary_in;
            ov_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            dec_d   = '0;
            ov_d    = 1'b0;
          end
        end

        ST_GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (accept) begin
              pend_valid_d = 1'b1;
              pend_code_d  = binary_in;
            end
          end else if (pend_valid_q) begin
            state_d      = ST_DRIVE;
            cnt_d        = HOLD_RELOAD;
            dec_d        = OUT_W'(1) << pend_code_q;
            ov_d         = 1'b1;
            pend_valid_d = 1'b0;
          end else if (accept) begin
            state_d = ST_DRIVE;
            cnt_d   = HOLD_RELOAD;
            dec_d   = OUT_W'(1) << binary_in;
            ov_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          dec_d        = '0;
          ov_d         = 1'b0;
          pend_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dec_q        <= '0;
      ov_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dec_q        <= dec_d;
      ov_q         <= ov_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pri_decoder_strobe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pri_decoder_strobe
// Purpose  : Directed self-checking bench for pri_decoder_strobe. dut_a uses
//            HOLD=2/GAP=1, dut_b uses HOLD=2/GAP=0; both share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pri_decoder_strobe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  binary_in;
  logic        in_valid;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [15:0] a_dec;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_dec;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pri_decoder_strobe #(.WIDTH_IN(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .binary_in   (binary_in),
    .in_valid    (in_valid),
    .in_ready    (a_in_ready),
    .decoder_out (a_dec),
    .out_valid   (a_out_valid),
    .busy        (a_busy)
  );

  pri_decoder_strobe #(.WIDTH_IN(4), .HOLD_CYCLES(2), .GAP_CYCLES(0)) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .binary_in   (binary_in),
    .in_valid    (in_valid),
    .in_ready    (b_in_ready),
    .decoder_out (b_dec),
    .out_valid   (b_out_valid),
    .busy        (b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [15:0] dec, input logic ov,
                         input logic rdy, input logic bsy);
    check({tag, ".dec"},   {16'h0, a_dec},  {16'h0, dec});
    check({tag, ".ov"},    {31'h0, a_out_valid}, {31'h0, ov});
    check({tag, ".ready"}, {31'h0, a_in_ready},  {31'h0, rdy});
    check({tag, ".busy"},  {31'h0, a_busy},      {31'h0, bsy});
  endtask

  initial begin
    // ---- 1: reset held with a valid code presented -------------------------
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b1; binary_in = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      check_a("t1_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      check("t1_rst.b_ready", {31'h0, b_in_ready}, 32'h0);
    end
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    check("t1_release.ready", {31'h0, a_in_ready}, 32'h1);

    // ---- 2: single accept of 5 ---------------------------------------------
    in_valid = 1'b1; binary_in = 4'd5;
    step(); in_valid = 1'b0;
    check_a("t2_e1", 16'h0020, 1'b1, 1'b1, 1'b1);
    step(); check_a("t2_e2", 16'h0020, 1'b1, 1'b1, 1'b1);
    step(); check_a("t2_gap", 16'h0000, 1'b0, 1'b1, 1'b1);
    step(); check_a("t2_idle", 16'h0000, 1'b0, 1'b1, 1'b0);

    // ---- 3: streaming 3, 15, 0 with in_valid held --------------------------
    in_valid = 1'b1; binary_in = 4'd3;
    step(); binary_in = 4'd15;               // 3 accepted
    check_a("t3_e1", 16'h0008, 1'b1, 1'b1, 1'b1);
    step(); binary_in = 4'd0;                // 15 accepted into pending
    check_a("t3_e2", 16'h0008, 1'b1, 1'b0, 1'b1);
    step(); check_a("t3_e3", 16'h0000, 1'b0, 1'b0, 1'b1);
    step(); check_a("t3_e4", 16'h8000, 1'b1, 1'b1, 1'b1);
    step(); in_valid = 1'b0;                 // 0 accepted into pending
    check_a("t3_e5", 16'h8000, 1'b1, 1'b0, 1'b1);
    step(); check_a("t3_e6", 16'h0000, 1'b0, 1'b0, 1'b1);
    step(); check_a("t3_e7", 16'h0001, 1'b1, 1'b1, 1'b1);
    step(); check_a("t3_e8", 16'h0001, 1'b1, 1'b1, 1'b1);
    step(); check_a("t3_e9", 16'h0000, 1'b0, 1'b1, 1'b1);
    step(); check_a("t3_e10", 16'h0000, 1'b0, 1'b1, 1'b0);

    // ---- 4: enable dropped with a pending entry ----------------------------
    in_valid = 1'b1; binary_in = 4'd9;
    step(); binary_in = 4'd2;
    check_a("t4_e1", 16'h0200, 1'b1, 1'b1, 1'b1);
    step(); in_valid = 1'b0; enable = 1'b0;  // 2 in pending, second DRIVE clock
    check_a("t4_e2", 16'h0200, 1'b1, 1'b0, 1'b1);
    step(); check_a("t4_abort", 16'h0000, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); check_a("t4_after", 16'h0000, 1'b0, 1'b1, 1'b0);
    end

    // ---- 5: GAP=0 back-to-back on dut_b ------------------------------------
    in_valid = 1'b1; binary_in = 4'd1;
    step(); binary_in = 4'd2;
    check("t5_e1.b_dec", {16'h0, b_dec}, 32'h0002);
    step(); in_valid = 1'b0;
    check("t5_e2.b_dec", {16'h0, b_dec}, 32'h0002);
    check("t5_e2.b_ready", {31'h0, b_in_ready}, 32'h0);
    step(); check("t5_e3.b_dec", {16'h0, b_dec}, 32'h0004);
    check("t5_e3.b_ov", {31'h0, b_out_valid}, 32'h1);
    step(); check("t5_e4.b_dec", {16'h0, b_dec}, 32'h0004);
    step(); check("t5_e5.b_dec", {16'h0, b_dec}, 32'h0000);
    check("t5_e5.b_busy", {31'h0, b_busy}, 32'h0);
    for (int i = 0; i < 3; i++) step();
    check("t5_settle.a_busy", {31'h0, a_busy}, 32'h0);

    // ---- 6: reset during DRIVE with pending --------------------------------
    in_valid = 1'b1; binary_in = 4'd12;
    step(); binary_in = 4'd3;
    check_a("t6_e1", 16'h1000, 1'b1, 1'b1, 1'b1);
    step(); in_valid = 1'b0; reset_n = 1'b0;
    #1;
    check("t6_rstlow.ready", {31'h0, a_in_ready}, 32'h0);
    step(); check_a("t6_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("t6_rst.b_dec", {16'h0, b_dec}, 32'h0000);
    check("t6_rst.b_busy", {31'h0, b_busy}, 32'h0);
    reset_n = 1'b1; in_valid = 1'b1; binary_in = 4'd0;
    #1;
    check("t6_release.ready", {31'h0, a_in_ready}, 32'h1);
    step(); in_valid = 1'b0;
    check_a("t6_fresh", 16'h0001, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pri_decoder_strobe.md
Name: pri_decoder_strobe

Overview:
- Binary-to-one-hot decoder with sequential strobe generation; the decode direction of the 16-line priority encoder path.
- Accepts a 4-bit code over a valid/ready handshake and drives the matching one-hot line of a 16-bit output for HOLD_CYCLES clocks.
- Then forces an optional idle gap.
- A one-entry pending buffer allows a new code to be accepted while a strobe is in progress.

Parameters:
- WIDTH_IN, 4: code width; output width is 2**WIDTH_IN.
- HOLD_CYCLES, 2: clocks each one-hot strobe is held; legal range 1 or more.
- GAP_CYCLES, 1: forced all-zero clocks after each strobe; 0 means strobes may run back-to-back.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active low.
- enable  input  1  block enable; low aborts and blocks accepts.
- binary_in  input  WIDTH_IN  code to decode.
- in_valid  input  1  binary_in valid.
- in_ready  output  1  block can accept a code this cycle.
- decoder_out  output  2**WIDTH_IN  one-hot strobe; all zero when no strobe is active.
- out_valid  output  1  high while decoder_out is nonzero.
- busy  output  1  strobe active, gap active, or pending entry held.

Behaviour:
- Reset (reset_n low at a clk edge):
  - decoder_out=0, out_valid=0, pending cleared, state=IDLE, counter=0.
  - in_ready is low during every reset_n-low cycle.
  - Reset mid-operation discards the active strobe and the pending code with no completion.
- in_ready = reset_n & enable & ~pend_valid (combinational).
- Handshake: the code is accepted at an edge where in_valid & in_ready are both high. binary_in is sampled only at that edge.
- States: IDLE, DRIVE, GAP. The down-counter is sized to hold max(HOLD_CYCLES, GAP_CYCLES)-1.
- IDLE:
  - Accept with the pending buffer empty loads the code directly: decoder_out <= 1<<binary_in, out_valid<=1, cnt<=HOLD_CYCLES-1, go to DRIVE.
  - Latency: one clock from the handshake edge to the strobe being visible.
- DRIVE:
  - decoder_out holds its value. cnt decrements each clock.
  - An accept during DRIVE is written into the pending buffer.
  - At cnt==0 with GAP_CYCLES>0: decoder_out<=0, out_valid<=0, cnt<=GAP_CYCLES-1, go to GAP.
  - At cnt==0 with GAP_CYCLES==0:
    - If pending is valid, load it (new one-hot, cnt reload) and clear pending.
    - Else, if an accept happens at the same edge, load the incoming code directly (bypass).
    - Else, go to IDLE with outputs 0.
- GAP:
  - Outputs are 0. cnt decrements.
  - At cnt==0: if pending is valid, load it into DRIVE and clear pending. Else, if an accept happens at the same edge, bypass-load it into DRIVE. Else, go to IDLE.
- Simultaneous events at a pending-load edge:
  - The pending entry is cleared at that edge.
  - in_ready was low during that cycle, so no accept can coincide with the pending load.
- Pending-full back-pressure: in_ready stays low until the pending entry is consumed. in_valid may stay high while in_ready is low; the upstream must hold binary_in stable.
- enable low, sampled at an edge:
  - decoder_out<=0, out_valid<=0, pending cleared, state<=IDLE.
  - Takes effect at that edge regardless of state. No partial strobe resumes after enable returns.
- busy = (state!=IDLE) | pend_valid.
- Output invariants:
  - decoder_out is always zero or exactly one-hot.
  - out_valid == |decoder_out.
  - All outputs are registered except in_ready and busy.

Test Plan:
1. Reset with in_valid=1, enable=1, binary_in=4'd7 for 3 cycles -> in_ready=0, decoder_out=16'h0000, busy=0 throughout. First cycle after release: in_ready=1.
2. HOLD=2, GAP=1, single accept of 4'd5 -> decoder_out=16'h0020 with out_valid=1 for 2 clocks, then 16'h0000 for 1 clock, then IDLE; busy=0 afterward.
3. HOLD=2, GAP=1, in_valid held high with codes 3, 15, 0 presented in order:
   - Output: 16'h0008 x2, 0 x1, 16'h8000 x2, 0 x1, 16'h0001 x2.
   - in_ready is low from the clock after 15 is accepted until the gap-end edge that loads 15.
4. Accept 4'd9, then accept 4'd2 into pending, then drop enable in the second DRIVE clock -> next edge: decoder_out=0, out_valid=0, busy=0. Code 2 never appears after enable returns.
5. GAP=0, HOLD=2, back-to-back accepts of 1 then 2 -> decoder_out=16'h0002, 16'h0002, 16'h0004, 16'h0004 with no zero clock between strobes.
6. Assert reset_n low during DRIVE of code 4'd12 with a pending entry present -> next edge: all outputs 0 and pending cleared. After release, a fresh accept of 4'd0 gives 16'h0001 one clock later.
